// File: rtl/alu_result_display_pkg.sv
// Shared constants for the ALU result display: seven-segment decode table,
// flag bit positions and the active-low blank pattern.
package alu_result_display_pkg;

    // Flag bit positions within the 4-bit flags word.
    localparam int FLAG_ZF = 0;
    localparam int FLAG_CF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_SF = 3;

    // All segments off, decimal point off (active-low).
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Hex digit to gfedcba, active-low. Entry 0 sits in the low bits.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/alu_result_display_btn_debounce.sv
// Button conditioner: two-flop synchronizer, debounce FSM and a one-cycle
// pulse on the cycle after an accepted press.
//
//   state  | meaning
//   -------+------------------------------------------------
//   S_LOW  | button accepted as released
//   S_HIGH | button accepted as pressed
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    typedef enum logic {S_LOW = 1'b0, S_HIGH = 1'b1} deb_state_t;

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic           sync_1;
    logic           sync_2;
    deb_state_t     state;
    deb_state_t     state_prev;
    deb_state_t     state_nxt;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nxt;

    // State register, synchronizer and debounce counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            state      <= S_LOW;
            state_prev <= S_LOW;
            cnt        <= '0;
        end else begin
            sync_1     <= btn;
            sync_2     <= sync_1;
            state      <= state_nxt;
            state_prev <= state;
            cnt        <= cnt_nxt;
        end
    end

    // Toggle only after the synchronized level has disagreed for DEB_CYCLES cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        if (sync_2 != (state == S_HIGH)) begin
            if (cnt == CNT_MAX) begin
                state_nxt = (state == S_HIGH) ? S_LOW : S_HIGH;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    // Pulse is high during the cycle following the S_LOW -> S_HIGH transition.
    always_comb begin
        rise = (state == S_HIGH) && (state_prev == S_LOW);
    end

endmodule

// File: rtl/alu_result_display.sv
// Captures the ALU result and flags on a debounced button press and shows the
// result as 8 hex digits on a multiplexed seven-segment display.
import alu_result_display_pkg::*;

module alu_result_display #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] result,
    input  logic [3:0]  flags,
    input  logic        cap_btn,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic [3:0]  led,
    output logic        valid
);

    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    logic          cap_pulse;
    logic [31:0]   cap_result;
    logic [3:0]    cap_flags;
    logic          valid_q;
    logic [SW-1:0] scan_cnt;
    logic [2:0]    digit_idx;
    logic [3:0]    cur_nib;
    logic [7:0]    an_q;
    logic [7:0]    seg_q;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (cap_btn),
        .rise  (cap_pulse)
    );

    // Snapshot result and flags once per accepted press; valid is sticky.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_result <= '0;
            cap_flags  <= '0;
            valid_q    <= 1'b0;
        end else if (cap_pulse) begin
            cap_result <= result;
            cap_flags  <= flags;
            valid_q    <= 1'b1;
        end
    end

    assign cur_nib = cap_result[{digit_idx, 2'b00} +: 4];

    // Scan timer, digit index and registered anode/segment drive.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            an_q      <= 8'hFE;
            seg_q     <= SEG_BLANK;
        end else begin
            if (scan_cnt == SCAN_MAX) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            an_q  <= ~(8'h01 << digit_idx);
            seg_q <= valid_q ? {1'b1, SEG_HEX[cur_nib]} : SEG_BLANK;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign valid = valid_q;
    assign led   = {cap_flags[FLAG_SF], cap_flags[FLAG_OF],
                    cap_flags[FLAG_CF], cap_flags[FLAG_ZF]};

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with small scan/debounce parameters.
module tb_alu_result_display;

    localparam int SCAN_DIV   = 4;
    localparam int DEB_CYCLES = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        cap_btn;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [3:0]  led;
    logic        valid;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0]      result;
        logic [3:0]       flags;
        logic [7:0][6:0]  codes;   // expected gfedcba per digit, digit 7 first
    } vec_t;

    vec_t vecs[5];

    alu_result_display #(
        .SCAN_DIV   (SCAN_DIV),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .result  (result),
        .flags   (flags),
        .cap_btn (cap_btn),
        .an      (an),
        .seg     (seg),
        .led     (led),
        .valid   (valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Align to the start of digit 0 (an 7F -> FE), then check one full scan
    // frame of 4 cycles per digit plus the wrap back to digit 0.
    task automatic observe(input string name, input logic [7:0][6:0] codes, input bit blank);
        logic [7:0] prev_an;
        logic [7:0] exp_seg;
        bit found;
        found   = 0;
        prev_an = an;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (an == 8'hFE && prev_an == 8'h7F) begin
                found = 1;
                break;
            end
            prev_an = an;
        end
        check({name, "_align"}, 32'(found), 32'd1);
        if (found) begin
            for (int i = 0; i < 33; i++) begin
                int d;
                d = (i / 4) % 8;
                exp_seg = blank ? 8'hFF : {1'b1, codes[d]};
                check({name, "_an"}, {24'h0, an}, {24'h0, ~(8'h01 << d)});
                check({name, "_seg"}, {24'h0, seg}, {24'h0, exp_seg});
                tick();
            end
        end
    endtask

    // Press and wait for led to show the new flags within DEB_CYCLES+4 cycles,
    // hold the button 10 cycles in total, then release and let it settle.
    task automatic press_capture(input string name, input logic [3:0] exp_led);
        int n;
        bit seen;
        seen    = 0;
        n       = 0;
        cap_btn = 1'b1;
        while (n < DEB_CYCLES + 4) begin
            tick();
            n++;
            if (valid === 1'b1 && led === exp_led) begin
                seen = 1;
                break;
            end
        end
        check({name, "_cap_latency"}, 32'(seen), 32'd1);
        while (n < 10) begin
            tick();
            n++;
        end
        cap_btn = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        vecs[0] = '{32'h1234_5678, 4'b0001,
                    {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}};
        vecs[1] = '{32'h8000_0000, 4'b1110, {7'h00, {7{7'h40}}}};
        vecs[2] = '{32'h7FFF_FFFF, 4'b0100, {7'h78, {7{7'h0E}}}};
        vecs[3] = '{32'hFFFF_FFFF, 4'b1010, {8{7'h0E}}};
        vecs[4] = '{32'h9ABC_DEF0, 4'b0011,
                    {7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h40}};

        // Reset held with button pressed.
        rst_n   = 1'b0;
        cap_btn = 1'b1;
        result  = 32'hDEAD_BEEF;
        flags   = 4'hF;
        repeat (5) tick();
        check("rst_an", {24'h0, an}, 32'hFE);
        check("rst_seg", {24'h0, seg}, 32'hFF);
        check("rst_led", {28'h0, led}, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        rst_n   = 1'b1;
        cap_btn = 1'b0;
        repeat (10) tick();
        check("post_rst_valid", {31'h0, valid}, 32'h0);

        // Short glitches must never be accepted.
        result = 32'hFFFF_FFFF;
        flags  = 4'hF;
        for (int p = 0; p < 5; p++) begin
            cap_btn = 1'b1;
            repeat (2) tick();
            cap_btn = 1'b0;
            repeat (2) tick();
            check("glitch_seg", {24'h0, seg}, 32'hFF);
        end
        repeat (8) tick();
        check("glitch_valid", {31'h0, valid}, 32'h0);
        check("glitch_led", {28'h0, led}, 32'h0);
        observe("glitch_blank", '0, 1'b1);

        // Table: capture, then disturb inputs and confirm the display holds.
        for (int v = 0; v < 5; v++) begin
            result = vecs[v].result;
            flags  = vecs[v].flags;
            press_capture($sformatf("vec%0d", v), vecs[v].flags);
            result = ~vecs[v].result;
            flags  = ~vecs[v].flags;
            observe($sformatf("vec%0d", v), vecs[v].codes, 1'b0);
            check($sformatf("vec%0d_led", v), {28'h0, led}, {28'h0, vecs[v].flags});
            check($sformatf("vec%0d_valid", v), {31'h0, valid}, 32'h1);
        end

        // A long hold captures only once: inputs changed mid-hold are ignored.
        result  = 32'h0000_00A5;
        flags   = 4'b0101;
        cap_btn = 1'b1;
        repeat (10) tick();
        check("hold_led", {28'h0, led}, 32'h5);
        result = 32'h1111_1111;
        flags  = 4'b1000;
        repeat (30) tick();
        cap_btn = 1'b0;
        repeat (10) tick();
        observe("hold_once", {{6{7'h40}}, 7'h08, 7'h12}, 1'b0);
        check("hold_once_led", {28'h0, led}, 32'h5);

        // Reset in the middle of a scan at digit 5.
        begin
            bit found;
            found = 0;
            for (int i = 0; i < 50; i++) begin
                if (an == 8'hDF) begin
                    found = 1;
                    break;
                end
                tick();
            end
            check("midrst_reach_d5", 32'(found), 32'd1);
        end
        rst_n = 1'b0;
        tick();
        check("midrst_an", {24'h0, an}, 32'hFE);
        check("midrst_seg", {24'h0, seg}, 32'hFF);
        check("midrst_valid", {31'h0, valid}, 32'h0);
        check("midrst_led", {28'h0, led}, 32'h0);
        rst_n = 1'b1;
        observe("midrst_blank", '0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
